// File: rtl/umsg_sched.sv
// umsg_sched: per-slot UMsg delay scheduler with a round-robin emission arbiter.
// Optional hint path is compiled in only when ASE_UMSG_HINT_EN is defined.
module umsg_sched #(
    parameter int  NUM_UMSG    = 8,
    parameter int  TIMER_WIDTH = 8,
    parameter int  HINT_DELAY  = 8,
    parameter int  DATA_DELAY  = 16,
    localparam int ID_W        = $clog2(NUM_UMSG)
) (
    input  logic                clk,
    input  logic                SoftReset,
    input  logic                cmd_valid,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic                cmd_hint,
    input  logic [511:0]        cmd_data,
    output logic                cmd_ready,
    input  logic                rx_stall,
    output logic                umsg_valid,
    output logic                umsg_type,
    output logic [ID_W-1:0]     umsg_id,
    output logic [511:0]        umsg_data,
    output logic [NUM_UMSG-1:0] slot_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HINT_WAIT,
        S_SEND_HINT,
        S_DATA_WAIT,
        S_SEND_DATA
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] HINT_T = TIMER_WIDTH'(HINT_DELAY);
    localparam logic [TIMER_WIDTH-1:0] DATA_T = TIMER_WIDTH'(DATA_DELAY);

    state_t                 r_state     [NUM_UMSG];
    state_t                 w_state_nxt [NUM_UMSG];
    logic [TIMER_WIDTH-1:0] r_timer     [NUM_UMSG];
    logic [TIMER_WIDTH-1:0] w_timer_nxt [NUM_UMSG];
    logic [511:0]           r_data      [NUM_UMSG];
    logic [ID_W-1:0]        r_ptr;

    logic                   r_umsg_valid;
    logic                   r_umsg_type;
    logic [ID_W-1:0]        r_umsg_id;
    logic [511:0]           r_umsg_data;

    logic                   w_accept;
    logic                   w_use_hint;
    logic                   w_grant;
    logic                   w_grant_hint;
    logic [ID_W-1:0]        w_grant_id;
    logic [NUM_UMSG-1:0]    w_req;

`ifdef ASE_UMSG_HINT_EN
    assign w_use_hint   = cmd_hint;
    assign w_grant_hint = w_grant && (r_state[w_grant_id] == S_SEND_HINT);
`else
    logic w_unused_hint;
    assign w_unused_hint = cmd_hint;
    assign w_use_hint    = 1'b0;
    assign w_grant_hint  = 1'b0;
`endif

    assign cmd_ready = (r_state[cmd_id] == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        for (int i = 0; i < NUM_UMSG; i++) begin
            w_req[i]     = (r_state[i] == S_SEND_HINT) || (r_state[i] == S_SEND_DATA);
            slot_busy[i] = (r_state[i] != S_IDLE);
        end
    end

    // Scan requesters starting at the pointer; the first one found wins.
    always_comb begin
        logic [ID_W-1:0] v_idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_grant    = 1'b0;
        w_grant_id = '0;
        v_idx      = '0;
        if (!rx_stall) begin
            for (int k = 0; k < NUM_UMSG; k++) begin
                v_idx = r_ptr + ID_W'(k);
                if (!w_grant && w_req[v_idx]) begin
                    w_grant    = 1'b1;
                    w_grant_id = v_idx;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_UMSG; i++) begin
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            case (r_state[i])
                S_IDLE: begin
                    if (w_accept && (cmd_id == ID_W'(i))) begin
                        w_state_nxt[i] = w_use_hint ? S_HINT_WAIT : S_DATA_WAIT;
                        w_timer_nxt[i] = w_use_hint ? HINT_T : DATA_T;
                    end
                end
                S_HINT_WAIT: begin
                    if (r_timer[i] == '0) w_state_nxt[i] = S_SEND_HINT;
                    else                  w_timer_nxt[i] = r_timer[i] - 1'b1;
                end
                S_SEND_HINT: begin
                    if (w_grant && (w_grant_id == ID_W'(i))) begin
                        w_state_nxt[i] = S_DATA_WAIT;
                        w_timer_nxt[i] = DATA_T;
                    end
                end
                S_DATA_WAIT: begin
                    if (r_timer[i] == '0) w_state_nxt[i] = S_SEND_DATA;
                    else                  w_timer_nxt[i] = r_timer[i] - 1'b1;
                end
                S_SEND_DATA: begin
                    if (w_grant && (w_grant_id == ID_W'(i))) w_state_nxt[i] = S_IDLE;
                end
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    // NOTE: the payload array is reset too, since reset must leave no stale message data behind.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                r_state[i] <= S_IDLE;
                r_timer[i] <= '0;
                r_data[i]  <= '0;
            end
            r_ptr        <= '0;
            r_umsg_valid <= 1'b0;
            r_umsg_type  <= 1'b0;
            r_umsg_id    <= '0;
            r_umsg_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
            if (w_accept) r_data[cmd_id] <= cmd_data;
            if (w_grant)  r_ptr <= w_grant_id + 1'b1;
            r_umsg_valid <= w_grant;
            r_umsg_type  <= w_grant_hint;
            r_umsg_id    <= w_grant ? w_grant_id : '0;
            r_umsg_data  <= (w_grant && !w_grant_hint) ? r_data[w_grant_id] : '0;
        end
    end

    assign umsg_valid = r_umsg_valid;
    assign umsg_type  = r_umsg_type;
    assign umsg_id    = r_umsg_id;
    assign umsg_data  = r_umsg_data;

endmodule

// File: tb/tb_umsg_sched.sv
// tb_umsg_sched: directed and random stimulus against a deadline-based model of umsg_sched.
// Hint scenarios follow ASE_UMSG_HINT_EN, matching the RTL build.
module tb_umsg_sched;

  localparam int N = 8;
  localparam int H = 8;
  localparam int D = 16;
`ifdef ASE_UMSG_HINT_EN
  localparam bit HINT_EN = 1'b1;
`else
  localparam bit HINT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         SoftReset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd_id = '0;
  logic         cmd_hint = 1'b0;
  logic [511:0] cmd_data = '0;
  logic         cmd_ready;
  logic         rx_stall = 1'b0;
  logic         umsg_valid;
  logic         umsg_type;
  logic [2:0]   umsg_id;
  logic [511:0] umsg_data;
  logic [7:0]   slot_busy;

  umsg_sched #(.NUM_UMSG(N), .TIMER_WIDTH(8), .HINT_DELAY(H), .DATA_DELAY(D)) dut (
    .clk(clk), .SoftReset(SoftReset), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
    .cmd_hint(cmd_hint), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .rx_stall(rx_stall),
    .umsg_valid(umsg_valid), .umsg_type(umsg_type), .umsg_id(umsg_id),
    .umsg_data(umsg_data), .slot_busy(slot_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each busy slot holds the absolute edge from which it may be granted.
  typedef struct { bit busy; bit hint_pend; int ready_at; logic [511:0] data; } mslot_t;
  typedef struct { int cyc; logic [2:0] id; logic typ; logic [511:0] data; } emit_t;

  mslot_t       m [N];
  int           rr = 0;
  int           cyc = 0;
  bit           exp_valid = 1'b0;
  bit           exp_type = 1'b0;
  logic [2:0]   exp_id = '0;
  logic [511:0] exp_data = '0;
  emit_t        log_q [$];

  always @(posedge clk) begin
    bit acc;
    int g;
    int i;
    cyc++;
    if (SoftReset) begin
      for (int s = 0; s < N; s++) m[s] = '{1'b0, 1'b0, 0, '0};
      rr = 0;
      exp_valid = 1'b0;
      exp_type = 1'b0;
      exp_id = '0;
      exp_data = '0;
    end else begin
      check("cmd_ready", cmd_ready, !m[cmd_id].busy);
      acc = cmd_valid && !m[cmd_id].busy;
      g = -1;
      if (!rx_stall) begin
        for (int k = 0; k < N; k++) begin
          i = (rr + k) % N;
          if (g < 0 && m[i].busy && cyc >= m[i].ready_at) g = i;
        end
      end
      exp_valid = (g >= 0);
      exp_type = 1'b0;
      exp_id = '0;
      exp_data = '0;
      if (g >= 0) begin
        exp_id = 3'(g);
        exp_type = m[g].hint_pend;
        exp_data = m[g].hint_pend ? '0 : m[g].data;
        rr = (g + 1) % N;
        if (m[g].hint_pend) begin
          m[g].hint_pend = 1'b0;
          m[g].ready_at = cyc + D + 2;
        end else begin
          m[g].busy = 1'b0;
        end
      end
      if (acc) begin
        m[cmd_id].busy = 1'b1;
        m[cmd_id].hint_pend = HINT_EN && cmd_hint;
        m[cmd_id].ready_at = cyc + ((HINT_EN && cmd_hint) ? H : D) + 2;
        m[cmd_id].data = cmd_data;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] eb;
    if (cyc > 0) begin
      check("umsg_valid", umsg_valid, exp_valid);
      if (exp_valid) begin
        check("umsg_type", umsg_type, exp_type);
        check("umsg_id", umsg_id, exp_id);
        check("umsg_data", umsg_data, exp_data);
      end
      for (int s = 0; s < N; s++) eb[s] = m[s].busy;
      check("slot_busy", slot_busy, eb);
      if (umsg_valid) log_q.push_back('{cyc, umsg_id, umsg_type, umsg_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    SoftReset = 1'b1;
    cmd_valid = 1'b0;
    rx_stall = 1'b0;
    @(negedge clk);
    SoftReset = 1'b0;
    check("rst_valid", umsg_valid, 0);
    check("rst_type", umsg_type, 0);
    check("rst_id", umsg_id, 0);
    check("rst_data", umsg_data, 0);
    check("rst_busy", slot_busy, 0);
    log_q.delete();
  endtask

  // Presents one command for a single edge; returns that edge's number and cmd_ready.
  task automatic issue(input logic [2:0] id, input bit hint, input logic [511:0] d,
                       output int e0, output bit rdy);
    cmd_valid = 1'b1;
    cmd_id = id;
    cmd_hint = hint;
    cmd_data = d;
    #1;
    rdy = cmd_ready;
    e0 = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    int e0, e1;
    bit rdy;
    logic [511:0] d1, d2;

    // Single data-only message.
    do_reset();
    d1 = {64{8'hA5}};
    issue(3'd3, 1'b0, d1, e0, rdy);
    check("t34_ready", rdy, 1);
    tick(25);
    check("t34_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("t34_cyc", log_q[0].cyc, e0 + 18);
      check("t34_id", log_q[0].id, 3);
      check("t34_type", log_q[0].typ, 0);
      check("t34_data", log_q[0].data, d1);
    end
    check("t34_busy", slot_busy, 0);

    // Hint request: hint then data with the macro on, data only with it off.
    do_reset();
    d1 = rand512();
`ifdef ASE_UMSG_HINT_EN
    issue(3'd5, 1'b1, d1, e0, rdy);
    tick(35);
    check("t35_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("t35_hint_cyc", log_q[0].cyc, e0 + 10);
      check("t35_hint_type", log_q[0].typ, 1);
      check("t35_hint_id", log_q[0].id, 5);
      check("t35_hint_data", log_q[0].data, 0);
      check("t35_data_cyc", log_q[1].cyc, e0 + 28);
      check("t35_data_type", log_q[1].typ, 0);
      check("t35_data_id", log_q[1].id, 5);
      check("t35_data_data", log_q[1].data, d1);
    end
`else
    issue(3'd1, 1'b1, d1, e0, rdy);
    tick(35);
    check("t39_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("t39_cyc", log_q[0].cyc, e0 + 18);
      check("t39_type", log_q[0].typ, 0);
      check("t39_id", log_q[0].id, 1);
      check("t39_data", log_q[0].data, d1);
    end
`endif

    // Stall holds both requests; release drains them in round-robin order.
    do_reset();
    rx_stall = 1'b1;
    issue(3'd0, 1'b0, rand512(), e0, rdy);
    issue(3'd7, 1'b0, rand512(), e1, rdy);
    tick(38);
    rx_stall = 1'b0;
    tick(10);
    check("t36_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("t36_first_cyc", log_q[0].cyc, e0 + 40);
      check("t36_first_id", log_q[0].id, 0);
      check("t36_second_cyc", log_q[1].cyc, e0 + 41);
      check("t36_second_id", log_q[1].id, 7);
    end

    // Second command to a busy slot is ignored.
    do_reset();
    d1 = rand512();
    d2 = ~d1;
    issue(3'd3, 1'b0, d1, e0, rdy);
    tick(4);
    issue(3'd3, 1'b0, d2, e1, rdy);
    check("t37_ready", rdy, 0);
    tick(20);
    check("t37_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("t37_cyc", log_q[0].cyc, e0 + 18);
      check("t37_data", log_q[0].data, d1);
    end

    // Reset mid-flight discards the pending message.
    do_reset();
    issue(3'd2, 1'b0, rand512(), e0, rdy);
    tick(5);
    SoftReset = 1'b1;
    @(negedge clk);
    SoftReset = 1'b0;
    check("t38_busy", slot_busy, 0);
    tick(40);
    check("t38_count", log_q.size(), 0);

    // Random traffic, stalls and occasional resets against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_id = 3'($urandom_range(0, N - 1));
      cmd_hint = ($urandom_range(0, 1) == 1);
      cmd_data = rand512();
      rx_stall = ($urandom_range(0, 3) == 0);
      SoftReset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rx_stall = 1'b0;
    SoftReset = 1'b0;
    tick(80);
    check("drain_busy", slot_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
